// File: rtl/led_shift_engine.sv
// Prescaled marquee engine: loads a WIDTH-bit pattern from the switches and shifts/rotates it by STEP bits every TICK_DIV cycles.
// Optional LED_SHIFT_SYNC_EN adds a 2-flop synchroniser on load/en/mode (adds 2 cycles of control latency).
module led_shift_engine #(
    parameter int WIDTH    = 24,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 100000000,
    parameter int CNT_W    = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             load,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic             load_c;
    logic             en_c;
    logic [1:0]       mode_c;

    logic [WIDTH-1:0] led_reg;
    logic [WIDTH-1:0] led_next;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] rot_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             tick_reg;
    logic             zero_reg;
    logic             fire;

`ifdef LED_SHIFT_SYNC_EN
    logic [1:0] load_sync_reg;
    logic [1:0] en_sync_reg;
    logic [1:0] mode_sync1_reg;
    logic [1:0] mode_sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_sync_reg  <= '0;
            en_sync_reg    <= '0;
            mode_sync1_reg <= '0;
            mode_sync2_reg <= '0;
        end else begin
            load_sync_reg  <= {load_sync_reg[0], load};
            en_sync_reg    <= {en_sync_reg[0], en};
            mode_sync1_reg <= mode;
            mode_sync2_reg <= mode_sync1_reg;
        end
    end

    assign load_c = load_sync_reg[1];
    assign en_c   = en_sync_reg[1];
    assign mode_c = mode_sync2_reg;
`else
    assign load_c = load;
    assign en_c   = en;
    assign mode_c = mode;
`endif

    // Rotate-left by STEP: bit gi takes the bit STEP positions below it, wrapping around.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
        assign rot_next[gi] = led_reg[(gi + WIDTH - STEP) % WIDTH];
    end

    always_comb begin
        shift_next = led_reg;
        case (mode_c)
            2'b01:   shift_next = led_reg << STEP;
            2'b10:   shift_next = led_reg >> STEP;
            2'b11:   shift_next = rot_next;
            default: shift_next = led_reg;
        endcase
    end

    assign fire = en_c && (cnt_reg == CNT_MAX);

    always_comb begin
        led_next = led_reg;
        if (load_c) begin
            led_next = sw;
        end else if (fire) begin
            led_next = shift_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_reg  <= '0;
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
            zero_reg <= 1'b1;
        end else begin
            led_reg  <= led_next;
            zero_reg <= (led_next == '0);
            if (load_c) begin
                cnt_reg  <= '0;
                tick_reg <= 1'b0;
            end else if (en_c) begin
                if (fire) begin
                    cnt_reg  <= '0;
                    tick_reg <= (mode_c != 2'b00);
                end else begin
                    cnt_reg  <= cnt_reg + 1'b1;
                    tick_reg <= 1'b0;
                end
            end else begin
                tick_reg <= 1'b0;
            end
        end
    end

    assign led  = led_reg;
    assign tick = tick_reg;
    assign zero = zero_reg;

endmodule

// File: tb/tb_led_shift_engine.sv
// Self-checking bench for led_shift_engine: directed marquee scenarios plus randomized control traffic
// checked every cycle against a behavioural model (honours LED_SHIFT_SYNC_EN when defined).
module tb_led_shift_engine;

    localparam int WIDTH    = 24;
    localparam int STEP     = 1;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 3;
    localparam logic [63:0] MASK = (64'd1 << WIDTH) - 64'd1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sw;
    logic             load;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] led;
    logic             tick;
    logic             zero;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    led_shift_engine #(
        .WIDTH(WIDTH), .STEP(STEP), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .load(load), .en(en), .mode(mode),
        .led(led), .tick(tick), .zero(zero)
    );

    always #5 clk = ~clk;

    // Behavioural model: pattern as an integer, events every TICK_DIV enabled cycles since the last load.
    function automatic logic [WIDTH-1:0] apply(input logic [WIDTH-1:0] p, input logic [1:0] m);
        logic [63:0] x;
        x = 64'(p);
        case (m)
            2'b01:   x = (x << STEP) & MASK;
            2'b10:   x = x >> STEP;
            2'b11:   x = ((x << STEP) | (x >> (WIDTH - STEP))) & MASK;
            default: x = x;
        endcase
        return x[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] m_led;
    logic             m_tick;
    int               m_elapsed;
    logic             c_load;
    logic             c_en;
    logic [1:0]       c_mode;

`ifdef LED_SHIFT_SYNC_EN
    logic [1:0] ld_d, en_d;
    logic [1:0] md_d0, md_d1;
    assign c_load = ld_d[1];
    assign c_en   = en_d[1];
    assign c_mode = md_d1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_d <= '0; en_d <= '0; md_d0 <= '0; md_d1 <= '0;
        end else begin
            ld_d <= {ld_d[0], load}; en_d <= {en_d[0], en}; md_d0 <= mode; md_d1 <= md_d0;
        end
    end
`else
    assign c_load = load;
    assign c_en   = en;
    assign c_mode = mode;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_led <= '0; m_tick <= 1'b0; m_elapsed <= 0;
        end else if (c_load) begin
            m_led <= sw; m_tick <= 1'b0; m_elapsed <= 0;
        end else if (c_en) begin
            m_elapsed <= m_elapsed + 1;
            if ((m_elapsed + 1) % TICK_DIV == 0) begin
                m_led  <= apply(m_led, c_mode);
                m_tick <= (c_mode != 2'b00);
            end else begin
                m_tick <= 1'b0;
            end
        end else begin
            m_tick <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            checks++;
            if (led !== m_led || tick !== m_tick || zero !== (m_led == '0)) begin
                errors++;
                $display("FAIL model_cmp t=%0t led=%h exp=%h tick=%b exp=%b zero=%b exp=%b",
                         $time, led, m_led, tick, m_tick, zero, (m_led == '0));
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end else begin
            $display("ok   %s value=%h", nm, act);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; sw = '0; load = 1'b0; en = 1'b0; mode = 2'b00;
        cyc(3);
        chk("reset_led", 64'(led), 64'h0);
        chk("reset_zero", 64'(zero), 64'h1);
        chk("reset_tick", 64'(tick), 64'h0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        cyc(10);
        chk("idle_led", 64'(led), 64'h0);

`ifndef LED_SHIFT_SYNC_EN
        // Shift left a single one through the whole bank and off the end.
        sw = 24'h000001; load = 1'b1; mode = 2'b01; en = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("sl_load", 64'(led), 64'h1);
        for (int k = 1; k <= WIDTH; k++) begin
            cyc(3);
            if (k == 1) chk("sl_pre_event", 64'(led), 64'h1);
            cyc(1);
            if (k == 1 || k == 2 || k == 3 || k == 23 || k == 24) begin
                chk($sformatf("sl_event%0d_led", k), 64'(led), (k < WIDTH) ? (64'd1 << k) : 64'h0);
                chk($sformatf("sl_event%0d_tick", k), 64'(tick), 64'h1);
            end
        end
        chk("sl_final_zero", 64'(zero), 64'h1);

        // Rotate: wraps the MSB into bit 0 and returns home after WIDTH events.
        sw = 24'h800001; load = 1'b1; mode = 2'b11;
        cyc(1);
        load = 1'b0;
        cyc(TICK_DIV);
        chk("rot_first", 64'(led), 64'h000003);
        cyc(TICK_DIV * (WIDTH - 1));
        chk("rot_full_turn", 64'(led), 64'h800001);

        // Shift right down to zero, then hold mode must not tick.
        sw = 24'h000003; load = 1'b1; mode = 2'b10;
        cyc(1);
        load = 1'b0;
        cyc(TICK_DIV);
        chk("sr_first", 64'(led), 64'h000001);
        cyc(TICK_DIV);
        chk("sr_second", 64'(led), 64'h0);
        chk("sr_zero", 64'(zero), 64'h1);
        mode = 2'b00;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            if (k == 7) chk("hold_tick", 64'(tick), 64'h0);
        end
        chk("hold_led", 64'(led), 64'h0);

        // Load held high with en=1: pattern sticks, prescaler stays cleared.
        sw = 24'hA5A5A5; load = 1'b1; mode = 2'b01; en = 1'b1;
        cyc(10);
        chk("loadhold_led", 64'(led), 64'hA5A5A5);
        chk("loadhold_tick", 64'(tick), 64'h0);
        load = 1'b0;
        cyc(TICK_DIV - 1);
        chk("loadhold_no_early", 64'(led), 64'hA5A5A5);
        cyc(1);
        chk("loadhold_first_shift", 64'(led), 64'h4B4B4A);
        cyc(TICK_DIV - 1);
        // Terminal cycle: load must win over the pending event.
        sw = 24'h123456; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("term_load_led", 64'(led), 64'h123456);
        chk("term_load_tick", 64'(tick), 64'h0);

        // Asynchronous reset in the middle of a count.
        mode = 2'b11; en = 1'b1;
        cyc(6);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_led", 64'(led), 64'h0);
        chk("midrst_zero", 64'(zero), 64'h1);
        chk("midrst_tick", 64'(tick), 64'h0);
        cyc(1);
        en = 1'b0;
        rst_n = 1'b1;
        cyc(10);
        chk("postrst_led", 64'(led), 64'h0);
`else
        // Synchronised load: visible two edges later than the direct path.
        sw = 24'h00ABCD; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("sync_load_n", 64'(led), 64'h0);
        cyc(1);
        chk("sync_load_n1", 64'(led), 64'h0);
        cyc(1);
        chk("sync_load_n2", 64'(led), 64'h00ABCD);
        mode = 2'b01; en = 1'b1;
        cyc(TICK_DIV + 1);
        chk("sync_en_no_shift", 64'(led), 64'h00ABCD);
        cyc(1);
        chk("sync_en_shift", 64'(led), 64'h01579A);
`endif

        // Randomized control traffic, checked every cycle by the model.
        for (int k = 0; k < 600; k++) begin
            load = ($urandom_range(15) == 0);
            en   = ($urandom_range(3) != 0);
            mode = 2'($urandom_range(3));
            sw   = WIDTH'($urandom);
            if ($urandom_range(7) == 0) sw = '0;
            cyc(1);
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
